// File: rtl/sel2_rr_arbiter.sv
// Two-requester round-robin packet arbiter driving a 2:1 selector.
// Grants are held for a whole packet; an idle-requester timeout forces release.
module sel2_rr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_A,
    input  logic [WIDTH-1:0] DATA_A,
    input  logic             LAST_A,
    input  logic             REQ_B,
    input  logic [WIDTH-1:0] DATA_B,
    input  logic             LAST_B,
    input  logic             OUT_READY,
    output logic             GNT_A,
    output logic             GNT_B,
    output logic             SEL,
    output logic             OUT_VALID,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_LAST,
    output logic             TIMEOUT_ERR
);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GA   = 2'd1;
    localparam logic [1:0] S_GB   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          sel_q, sel_d;
    logic          ptr_b_q, ptr_b_d;   // 1: B was served last, so A wins a tie
    logic [CW-1:0] cnt_q, cnt_d;
    logic          terr_q, terr_d;

    logic own_req, oth_req, own_last, xfer_last, tmo;

    assign GNT_A       = (state_q == S_GA);
    assign GNT_B       = (state_q == S_GB);
    assign SEL         = sel_q;
    assign TIMEOUT_ERR = terr_q;
    assign OUT_DATA    = sel_q ? DATA_B : DATA_A;
    assign OUT_LAST    = sel_q ? LAST_B : LAST_A;
    assign OUT_VALID   = ~RST & ((GNT_A & REQ_A) | (GNT_B & REQ_B));

    assign own_req   = GNT_B ? REQ_B  : REQ_A;
    assign oth_req   = GNT_B ? REQ_A  : REQ_B;
    assign own_last  = GNT_B ? LAST_B : LAST_A;
    assign xfer_last = OUT_VALID & OUT_READY & own_last;
    // Fires on the edge that closes the TIMEOUT-th consecutive idle cycle.
    assign tmo       = (GNT_A | GNT_B) & ~own_req & (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_b_d = ptr_b_q;
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (REQ_A && (!REQ_B || ptr_b_q)) begin
                    state_d = S_GA;
                    sel_d   = 1'b0;
                end else if (REQ_B) begin
                    state_d = S_GB;
                    sel_d   = 1'b1;
                end
            end
            S_GA, S_GB: begin
                if (xfer_last || tmo) begin
                    ptr_b_d = (state_q == S_GB);
                    terr_d  = ~xfer_last;
                    cnt_d   = '0;
                    if (oth_req) begin
                        state_d = (state_q == S_GA) ? S_GB : S_GA;
                        sel_d   = (state_q == S_GA);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (own_req) begin
                    cnt_d = '0;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            ptr_b_q <= 1'b1;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_b_q <= ptr_b_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end
endmodule

// File: tb/tb_sel2_rr_arbiter.sv
// Bench for sel2_rr_arbiter: packet-queue requesters, an ownership-level reference
// model compared every cycle, directed scenarios with literal expectations, random traffic.
module tb_sel2_rr_arbiter;
    localparam int W  = 8;
    localparam int TO = 4;

    logic         CLK = 1'b0;
    logic         RST, REQ_A, LAST_A, REQ_B, LAST_B, OUT_READY;
    logic [W-1:0] DATA_A, DATA_B, OUT_DATA;
    logic         GNT_A, GNT_B, SEL, OUT_VALID, OUT_LAST, TIMEOUT_ERR;

    sel2_rr_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_A(REQ_A), .DATA_A(DATA_A), .LAST_A(LAST_A),
        .REQ_B(REQ_B), .DATA_B(DATA_B), .LAST_B(LAST_B),
        .OUT_READY(OUT_READY),
        .GNT_A(GNT_A), .GNT_B(GNT_B), .SEL(SEL),
        .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct packed { logic [W-1:0] d; logic l; } beat_t;
    beat_t qa[$], qb[$];
    bit rst, rdy, drop_a, drop_b;
    bit acc_a, acc_b;

    int checks = 0, fails = 0;

    // Reference model: who owns the selector, who was served last, idle run length.
    int owner;     // 0 none, 1 A, 2 B
    bit m_sel, m_last_b, m_err;
    int lowrun;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive();
        RST       = rst;
        OUT_READY = rdy;
        REQ_A     = (qa.size() > 0) && !drop_a;
        DATA_A    = (qa.size() > 0) ? qa[0].d : '0;
        LAST_A    = (qa.size() > 0) ? qa[0].l : 1'b0;
        REQ_B     = (qb.size() > 0) && !drop_b;
        DATA_B    = (qb.size() > 0) ? qb[0].d : '0;
        LAST_B    = (qb.size() > 0) ? qb[0].l : 1'b0;
    endtask

    task automatic model_update();
        bit myreq, othreq, mylast, valid, done, tmo;
        if (rst) begin
            owner = 0; m_sel = 0; m_last_b = 1; lowrun = 0; m_err = 0;
            return;
        end
        m_err = 0;
        if (owner == 0) begin
            if (REQ_A && REQ_B) owner = m_last_b ? 1 : 2;
            else if (REQ_A)     owner = 1;
            else if (REQ_B)     owner = 2;
            if (owner != 0) m_sel = (owner == 2);
            lowrun = 0;
            return;
        end
        myreq  = (owner == 1) ? REQ_A  : REQ_B;
        othreq = (owner == 1) ? REQ_B  : REQ_A;
        mylast = (owner == 1) ? LAST_A : LAST_B;
        valid  = myreq;
        done   = valid && OUT_READY && mylast;
        tmo    = !myreq && (lowrun + 1 >= TO);
        if (done || tmo) begin
            m_last_b = (owner == 2);
            m_err    = !done;
            lowrun   = 0;
            if (othreq) begin
                owner = 3 - owner;
                m_sel = (owner == 2);
            end else begin
                owner = 0;
            end
        end else begin
            lowrun = myreq ? 0 : lowrun + 1;
        end
    endtask

    task automatic step();
        bit ev;
        @(negedge CLK);
        ev = !rst && ((owner == 1 && REQ_A) || (owner == 2 && REQ_B));
        chk("gnt_a", GNT_A, owner == 1);
        chk("gnt_b", GNT_B, owner == 2);
        chk("sel", SEL, m_sel);
        chk("out_valid", OUT_VALID, ev);
        chk("out_data", OUT_DATA, m_sel ? DATA_B : DATA_A);
        chk("out_last", OUT_LAST, m_sel ? LAST_B : LAST_A);
        chk("timeout_err", TIMEOUT_ERR, m_err);
        acc_a = (GNT_A === 1'b1) && REQ_A && OUT_READY && !rst;
        acc_b = (GNT_B === 1'b1) && REQ_B && OUT_READY && !rst;
        @(posedge CLK);
        model_update();
        #1;
        if (acc_a && qa.size() > 0) qa.delete(0);
        if (acc_b && qb.size() > 0) qb.delete(0);
        drive();
        #1;
    endtask

    task automatic drain();
        int n = 0;
        drop_a = 0; drop_b = 0; rdy = 1; drive();
        while ((qa.size() > 0 || qb.size() > 0 || owner != 0) && n < 80) begin
            step();
            n++;
        end
        if (n >= 80) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic push(input bit side_b, input logic [W-1:0] d, input bit l);
        beat_t b;
        b.d = d; b.l = l;
        if (side_b) qb.push_back(b); else qa.push_back(b);
    endtask

    initial begin
        rst = 1; rdy = 1; drop_a = 0; drop_b = 0;
        owner = 0; m_sel = 0; m_last_b = 1; lowrun = 0; m_err = 0;
        drive();

        // Reset then quiet bus
        repeat (2) step();
        rst = 0; drive();
        repeat (10) step();
        chk("idle_gnt_a", GNT_A, 0);
        chk("idle_sel", SEL, 0);
        chk("idle_valid", OUT_VALID, 0);

        // Single 3-beat packet from A
        push(0, 8'h11, 0); push(0, 8'h22, 0); push(0, 8'h33, 1); drive();
        step();
        chk("a_pkt_gnt", GNT_A, 1);
        chk("a_pkt_d0", OUT_DATA, 8'h11);
        chk("a_pkt_v0", OUT_VALID, 1);
        step(); chk("a_pkt_d1", OUT_DATA, 8'h22);
        step(); chk("a_pkt_d2", OUT_DATA, 8'h33); chk("a_pkt_last", OUT_LAST, 1);
        step(); chk("a_pkt_release", GNT_A, 0);

        // Simultaneous requests after reset: A first, B back-to-back, next tie A
        rst = 1; drive(); step(); rst = 0; drive();
        push(0, 8'hA1, 0); push(0, 8'hA2, 1); push(1, 8'hB1, 0); push(1, 8'hB2, 1); drive();
        step(); chk("tie_gnt_a", GNT_A, 1); chk("tie_sel_a", SEL, 0);
        step(); step();
        chk("tie_gnt_b", GNT_B, 1); chk("tie_sel_b", SEL, 1); chk("tie_b_data", OUT_DATA, 8'hB1);
        step(); step();
        push(0, 8'hA3, 1); push(1, 8'hB3, 1); drive();
        step(); chk("tie2_gnt_a", GNT_A, 1);
        drain();

        // B mid-packet with A waiting and downstream stalls
        push(1, 8'hC1, 0); push(1, 8'hC2, 0); push(1, 8'hC3, 1); drive();
        step(); step();
        push(0, 8'hD1, 1); rdy = 0; drive();
        step(); chk("stall_gnt_a", GNT_A, 0); chk("stall_data", OUT_DATA, 8'hC2);
        step(); chk("stall_gnt_b", GNT_B, 1); chk("stall_data2", OUT_DATA, 8'hC2);
        rdy = 1; drive();
        step(); step();
        chk("after_b_gnt_a", GNT_A, 1); chk("after_b_sel", SEL, 0);
        drain();

        // Timeout: A goes quiet mid-packet while B waits
        push(0, 8'h51, 0); push(0, 8'h52, 1); drive();
        step(); step();
        drop_a = 1; push(1, 8'h61, 1); drive();
        step(); step(); step();
        chk("tmo_pre_gnt_a", GNT_A, 1); chk("tmo_pre_err", TIMEOUT_ERR, 0);
        step();
        chk("tmo_gnt_a", GNT_A, 0); chk("tmo_gnt_b", GNT_B, 1); chk("tmo_err", TIMEOUT_ERR, 1);
        step(); chk("tmo_err_pulse", TIMEOUT_ERR, 0);
        drain();

        // Reset in the middle of a B packet
        push(1, 8'hE1, 0); push(1, 8'hE2, 0); push(1, 8'hE3, 1); drive();
        step(); step();
        rst = 1; drive();
        step(); chk("rst_gnt_b", GNT_B, 0); chk("rst_sel", SEL, 0);
        rst = 0; qa.delete(); qb.delete();
        push(0, 8'hF1, 1); push(1, 8'hF2, 1); drive();
        step(); chk("rst_tie_gnt_a", GNT_A, 1);
        drain();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (qa.size() == 0 && $urandom_range(0, 3) == 0) begin
                int len = $urandom_range(1, 4);
                for (int i = 0; i < len; i++) push(0, 8'($urandom), i == len - 1);
            end
            if (qb.size() == 0 && $urandom_range(0, 3) == 0) begin
                int len = $urandom_range(1, 4);
                for (int i = 0; i < len; i++) push(1, 8'($urandom), i == len - 1);
            end
            rdy = ($urandom_range(0, 3) != 0);
            if (drop_a) drop_a = ($urandom_range(0, 7) != 0); else drop_a = ($urandom_range(0, 19) == 0);
            if (drop_b) drop_b = ($urandom_range(0, 7) != 0); else drop_b = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 499) == 0);
            drive();
            step();
        end
        rst = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
